spi_xfer_arbiter: RTL and testbench



---
 rtl/spi_xfer_arbiter_pkg.sv | 32 +++
 rtl/spi_xfer_arbiter_if.sv | 45 ++++
 rtl/spi_toggle_writer.sv | 50 +++++
 rtl/spi_xfer_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 514 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_xfer_arbiter_pkg.sv
// Shared definitions for the SPI transfer arbiter.
//   state_e           : controller FSM states
//   *AddrDefault      : engine register addresses (CS, divider preset, data)
//   div_reload()      : true when the divider preset must be (re)written
package spi_xfer_arbiter_pkg;

  typedef enum logic [3:0] {
    StSync,
    StIdle,
    StDiv,
    StDivW,
    StCs1,
    StCs1W,
    StData,
    StDataW,
    StWaitRdy,
    StHold,
    StCs0,
    StCs0W
  } state_e;

  localparam logic [11:0] CsAddrDefault   = 12'h0B0;
  localparam logic [11:0] DivAddrDefault  = 12'h0B1;
  localparam logic [11:0] DataAddrDefault = 12'h0B2;

  function automatic logic div_reload(input logic       valid,
                                      input logic [7:0] cache,
                                      input logic [7:0] req_div);
    return !valid || (cache != req_div);
  endfunction

endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the SPI byte engine.
//   m0_* / m1_*    : requester handshake (req/hold/wdata/div in, ack/rdata out)
//   spi_*          : engine register-write toggle interface and receive data
//   busy / owner   : arbiter status
// Modport slave is the arbiter; master is the requesters plus engine side.
interface spi_xfer_arbiter_if;

  logic        m0_req;
  logic        m1_req;
  logic        m0_hold;
  logic        m1_hold;
  logic [7:0]  m0_wdata;
  logic [7:0]  m1_wdata;
  logic [7:0]  m0_div;
  logic [7:0]  m1_div;
  logic        m0_ack;
  logic        m1_ack;
  logic [7:0]  m0_rdata;
  logic [7:0]  m1_rdata;
  logic [11:0] spi_addr;
  logic [15:0] spi_din;
  logic        spi_iowr;
  logic        spi_iowr_echo;
  logic [15:0] spi_dout;
  logic        spi_ready;
  logic        busy;
  logic        owner;

  modport slave (
    input  m0_req, m1_req, m0_hold, m1_hold, m0_wdata, m1_wdata, m0_div, m1_div,
    input  spi_iowr_echo, spi_dout, spi_ready,
    output m0_ack, m1_ack, m0_rdata, m1_rdata,
    output spi_addr, spi_din, spi_iowr,
    output busy, owner
  );

  modport master (
    output m0_req, m1_req, m0_hold, m1_hold, m0_wdata, m1_wdata, m0_div, m1_div,
    output spi_iowr_echo, spi_dout, spi_ready,
    input  m0_ack, m1_ack, m0_rdata, m1_rdata,
    input  spi_addr, spi_din, spi_iowr,
    input  busy, owner
  );

endinterface

// File: rtl/spi_toggle_writer.sv
// Toggle-handshake register writer for the SPI byte engine.
//   start_i          : latch addr_i/data_i and invert iowr_o
//   addr_o / din_o   : held stable until the next start
//   echo_i / done_o  : done_o is high whenever the engine echo matches iowr_o
module spi_toggle_writer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [11:0] addr_i,
  input  logic [15:0] data_i,
  input  logic        echo_i,
  output logic        iowr_o,
  output logic [11:0] addr_o,
  output logic [15:0] din_o,
  output logic        done_o
);

  logic        iowr_q, iowr_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;

  always_comb begin
    iowr_d = iowr_q;
    addr_d = addr_q;
    din_d  = din_q;
    if (start_i) begin
      iowr_d = ~iowr_q;
      addr_d = addr_i;
      din_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iowr_q <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      iowr_q <= iowr_d;
      addr_q <= addr_d;
      din_q  <= din_d;
    end
  end

  assign iowr_o = iowr_q;
  assign addr_o = addr_q;
  assign din_o  = din_q;
  assign done_o = (echo_i == iowr_q);

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sequencing the SPI byte engine for two requesters.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus_io       : requester handshakes, engine write/receive signals, status
// Each byte: optional divider write, CS assert (unless held), data write,
// wait for engine ready, ack the owner; then hold CS or release it.
module spi_xfer_arbiter
  import spi_xfer_arbiter_pkg::*;
#(
  parameter logic [11:0] CS_ADDR   = CsAddrDefault,
  parameter logic [11:0] DIV_ADDR  = DivAddrDefault,
  parameter logic [11:0] DATA_ADDR = DataAddrDefault
) (
  input logic               clk,
  input logic               reset_n,
  spi_xfer_arbiter_if.slave bus_io
);

  state_e     state_q, state_d, chk_state;
  logic       owner_q, owner_d;
  logic       cs_state_q, cs_state_d;
  logic [7:0] div_cache_q, div_cache_d;
  logic       div_valid_q, div_valid_d;
  logic       m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic [7:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

  logic        wr_start, wr_done, wr_iowr;
  logic [11:0] wr_addr, wr_addr_out;
  logic [15:0] wr_data, wr_din_out;

  logic       sel, sel_req, sel_hold;
  logic [7:0] sel_wdata, sel_div;

  // Requester being served; in IDLE it is the one about to be granted.
  always_comb begin
    sel = owner_q;
    if (state_q == StIdle) begin
      if (bus_io.m0_req && bus_io.m1_req) sel = ~owner_q;
      else if (bus_io.m0_req)             sel = 1'b0;
      else if (bus_io.m1_req)             sel = 1'b1;
    end
  end

  assign sel_req   = sel ? bus_io.m1_req   : bus_io.m0_req;
  assign sel_hold  = sel ? bus_io.m1_hold  : bus_io.m0_hold;
  assign sel_wdata = sel ? bus_io.m1_wdata : bus_io.m0_wdata;
  assign sel_div   = sel ? bus_io.m1_div   : bus_io.m0_div;

  // Entry point for each byte: divider first if stale, then CS if released.
  assign chk_state = div_reload(div_valid_q, div_cache_q, sel_div) ? StDiv :
                     (cs_state_q ? StData : StCs1);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cs_state_d  = cs_state_q;
    div_cache_d = div_cache_q;
    div_valid_d = div_valid_q;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    wr_start    = 1'b0;
    wr_addr     = DATA_ADDR;
    wr_data     = '0;

    case (state_q)
      StSync: begin
        if (wr_done && bus_io.spi_ready) state_d = StIdle;
      end
      StIdle: begin
        if (bus_io.m0_req || bus_io.m1_req) begin
          owner_d = sel;
          state_d = chk_state;
        end
      end
      StDiv: begin
        wr_start    = 1'b1;
        wr_addr     = DIV_ADDR;
        wr_data     = {sel_div, 8'h00};
        div_cache_d = sel_div;
        div_valid_d = 1'b1;
        state_d     = StDivW;
      end
      StDivW: begin
        if (wr_done) state_d = cs_state_q ? StData : StCs1;
      end
      StCs1: begin
        wr_start   = 1'b1;
        wr_addr    = CS_ADDR;
        wr_data    = 16'h0001;
        cs_state_d = 1'b1;
        state_d    = StCs1W;
      end
      StCs1W: begin
        if (wr_done) state_d = StData;
      end
      StData: begin
        wr_start = 1'b1;
        wr_addr  = DATA_ADDR;
        wr_data  = {8'h00, sel_wdata};
        state_d  = StDataW;
      end
      StDataW: begin
        if (wr_done) state_d = StWaitRdy;
      end
      StWaitRdy: begin
        if (bus_io.spi_ready) begin
          if (sel) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = bus_io.spi_dout[7:0];
          end else begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = bus_io.spi_dout[7:0];
          end
          state_d = sel_hold ? StHold : StCs0;
        end
      end
      StHold: begin
        // req is stale while ack is still visible to the requester.
        if (!(m0_ack_q || m1_ack_q)) begin
          if (sel_req)        state_d = chk_state;
          else if (!sel_hold) state_d = StCs0;
        end
      end
      StCs0: begin
        wr_start   = 1'b1;
        wr_addr    = CS_ADDR;
        wr_data    = 16'h0000;
        cs_state_d = 1'b0;
        state_d    = StCs0W;
      end
      StCs0W: begin
        if (wr_done) state_d = StIdle;
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StSync;
      owner_q     <= 1'b1;
      cs_state_q  <= 1'b0;
      div_cache_q <= 8'hFF;
      div_valid_q <= 1'b0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cs_state_q  <= cs_state_d;
      div_cache_q <= div_cache_d;
      div_valid_q <= div_valid_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  spi_toggle_writer u_writer (
    .clk    (clk),
    .reset_n(reset_n),
    .start_i(wr_start),
    .addr_i (wr_addr),
    .data_i (wr_data),
    .echo_i (bus_io.spi_iowr_echo),
    .iowr_o (wr_iowr),
    .addr_o (wr_addr_out),
    .din_o  (wr_din_out),
    .done_o (wr_done)
  );

  assign bus_io.spi_iowr = wr_iowr;
  assign bus_io.spi_addr = wr_addr_out;
  assign bus_io.spi_din  = wr_din_out;
  assign bus_io.m0_ack   = m0_ack_q;
  assign bus_io.m1_ack   = m1_ack_q;
  assign bus_io.m0_rdata = m0_rdata_q;
  assign bus_io.m1_rdata = m1_rdata_q;
  assign bus_io.busy     = (state_q != StIdle);
  assign bus_io.owner    = owner_q;

  logic unused_dout;
  assign unused_dout = ^bus_io.spi_dout[15:8];

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
module tb_spi_xfer_arbiter;

  localparam logic [11:0] ACS   = 12'h0B0;
  localparam logic [11:0] ADIV  = 12'h0B1;
  localparam logic [11:0] ADATA = 12'h0B2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  spi_xfer_arbiter_if bus ();

  spi_xfer_arbiter dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus_io (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Engine model: logs decoded register writes, echoes toggles after
  // echo_delay cycles, and returns the inverted transmit byte as MISO.
  int          echo_delay = 0;
  int          echo_cnt = 0;
  int          xfer_cnt = 0;
  logic        iowr_seen = 1'b0;
  logic [7:0]  tx_byte = 8'h00;
  logic        eng_echo = 1'b0;
  logic        eng_ready = 1'b1;
  logic [15:0] eng_dout = 16'h0000;
  logic [11:0] log_addr[$];
  logic [15:0] log_din[$];

  assign bus.spi_iowr_echo = eng_echo;
  assign bus.spi_ready     = eng_ready;
  assign bus.spi_dout      = eng_dout;

  always @(posedge clk) begin
    if (xfer_cnt == 1) begin
      eng_ready <= 1'b1;
      eng_dout  <= {8'h00, ~tx_byte};
    end
    if (xfer_cnt != 0) xfer_cnt <= xfer_cnt - 1;
    if (bus.spi_iowr != iowr_seen) begin
      iowr_seen <= bus.spi_iowr;
      echo_cnt  <= echo_delay;
      if (bus.spi_addr >= ACS && bus.spi_addr <= ADATA) begin
        log_addr.push_back(bus.spi_addr);
        log_din.push_back(bus.spi_din);
      end
      if (bus.spi_addr == ADATA) begin
        eng_ready <= 1'b0;
        tx_byte   <= bus.spi_din[7:0];
        xfer_cnt  <= 8;
      end
    end else if (echo_cnt != 0) begin
      echo_cnt <= echo_cnt - 1;
    end else begin
      eng_echo <= iowr_seen;
    end
  end

  int ack0_cnt = 0;
  int ack1_cnt = 0;
  int both_cnt = 0;
  always @(negedge clk) begin
    if (bus.m0_ack === 1'b1) ack0_cnt++;
    if (bus.m1_ack === 1'b1) ack1_cnt++;
    if (bus.m0_ack === 1'b1 && bus.m1_ack === 1'b1) both_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input bit m, input bit req, input bit hold,
                         input logic [7:0] wdata, input logic [7:0] div);
    if (m) begin
      bus.m1_req = req; bus.m1_hold = hold; bus.m1_wdata = wdata; bus.m1_div = div;
    end else begin
      bus.m0_req = req; bus.m0_hold = hold; bus.m0_wdata = wdata; bus.m0_div = div;
    end
  endtask

  task automatic wait_ack(input bit m, input int bound, output bit got);
    got = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((m ? bus.m1_ack : bus.m0_ack) === 1'b1) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bit ok;
    #1 reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.spi_addr, bus.spi_din, bus.spi_iowr} !== 29'h0) begin
      errors++;
      $display("FAIL reset_spi: got addr=%h din=%h iowr=%b, expected all zero",
               bus.spi_addr, bus.spi_din, bus.spi_iowr);
    end
    checks++;
    if ({bus.m0_ack, bus.m1_ack, bus.m0_rdata, bus.m1_rdata} !== 18'h0) begin
      errors++;
      $display("FAIL reset_ack: got ack=%b%b rdata=%h/%h, expected zero",
               bus.m0_ack, bus.m1_ack, bus.m0_rdata, bus.m1_rdata);
    end
    checks++;
    if (bus.owner !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_status: got owner=%b busy=%b, expected 1/1", bus.owner, bus.busy);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_idle(50, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_sync_idle: busy=%b, expected 0 within 50 cycles", bus.busy);
    end
  endtask

  task automatic test_single();
    bit got, ok;
    int a0, a1;
    logic [11:0] ea[4];
    logic [15:0] ed[4];
    ea = '{ADIV, ACS, ADATA, ACS};
    ed = '{16'h0300, 16'h0001, 16'h00A5, 16'h0000};
    a0 = ack0_cnt; a1 = ack1_cnt;
    log_addr.delete(); log_din.delete();
    set_req(0, 1, 0, 8'hA5, 8'h03);
    wait_ack(0, 300, got);
    checks++;
    if (!got) begin errors++; $display("FAIL single_ack: no m0_ack, expected one"); end
    checks++;
    if (bus.m0_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL single_rdata: got %h, expected 5a", bus.m0_rdata);
    end
    set_req(0, 0, 0, 8'h00, 8'h03);
    wait_idle(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_idle: busy=%b, expected 0", bus.busy); end
    checks++;
    if (log_addr.size() != 4) begin
      errors++;
      $display("FAIL single_wr_count: got %0d, expected 4", log_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_addr[i] !== ea[i] || log_din[i] !== ed[i]) begin
          errors++;
          $display("FAIL single_wr[%0d]: got %h/%h, expected %h/%h",
                   i, log_addr[i], log_din[i], ea[i], ed[i]);
        end
      end
    end
    checks++;
    if (ack0_cnt - a0 != 1 || ack1_cnt - a1 != 0) begin
      errors++;
      $display("FAIL single_ack_count: got m0=%0d m1=%0d, expected 1/0",
               ack0_cnt - a0, ack1_cnt - a1);
    end
  endtask

  task automatic test_div_cache();
    bit got, ok;
    logic [11:0] ea[4];
    logic [15:0] ed[4];
    // Same divider: no preset write, CS is reasserted.
    ea = '{ACS, ADATA, ACS, 12'h000};
    ed = '{16'h0001, 16'h005A, 16'h0000, 16'h0000};
    log_addr.delete(); log_din.delete();
    set_req(0, 1, 0, 8'h5A, 8'h03);
    wait_ack(0, 300, got);
    checks++;
    if (!got || bus.m0_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL div_same_ack: got ack=%b rdata=%h, expected 1/a5", got, bus.m0_rdata);
    end
    set_req(0, 0, 0, 8'h00, 8'h03);
    wait_idle(300, ok);
    checks++;
    if (!ok || log_addr.size() != 3) begin
      errors++;
      $display("FAIL div_same_count: got idle=%b writes=%0d, expected 1/3", ok, log_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (log_addr[i] !== ea[i] || log_din[i] !== ed[i]) begin
          errors++;
          $display("FAIL div_same_wr[%0d]: got %h/%h, expected %h/%h",
                   i, log_addr[i], log_din[i], ea[i], ed[i]);
        end
      end
    end
    // New divider: preset rewritten before CS.
    ea = '{ADIV, ACS, ADATA, ACS};
    ed = '{16'h0700, 16'h0001, 16'h0011, 16'h0000};
    log_addr.delete(); log_din.delete();
    set_req(0, 1, 0, 8'h11, 8'h07);
    wait_ack(0, 300, got);
    checks++;
    if (!got || bus.m0_rdata !== 8'hEE) begin
      errors++;
      $display("FAIL div_new_ack: got ack=%b rdata=%h, expected 1/ee", got, bus.m0_rdata);
    end
    set_req(0, 0, 0, 8'h00, 8'h07);
    wait_idle(300, ok);
    checks++;
    if (!ok || log_addr.size() != 4) begin
      errors++;
      $display("FAIL div_new_count: got idle=%b writes=%0d, expected 1/4", ok, log_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_addr[i] !== ea[i] || log_din[i] !== ed[i]) begin
          errors++;
          $display("FAIL div_new_wr[%0d]: got %h/%h, expected %h/%h",
                   i, log_addr[i], log_din[i], ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_burst();
    bit got, ok;
    int a0, a1;
    logic [7:0]  wb[3];
    logic [11:0] ea[9];
    logic [15:0] ed[9];
    wb = '{8'h10, 8'h20, 8'h30};
    ea = '{ADIV, ACS, ADATA, ADATA, ADATA, ACS, ACS, ADATA, ACS};
    ed = '{16'h0300, 16'h0001, 16'h0010, 16'h0020, 16'h0030, 16'h0000,
           16'h0001, 16'h0077, 16'h0000};
    a0 = ack0_cnt; a1 = ack1_cnt;
    log_addr.delete(); log_din.delete();
    set_req(1, 1, 1, wb[0], 8'h03);
    for (int b = 0; b < 3; b++) begin
      wait_ack(1, 300, got);
      checks++;
      if (!got || bus.m1_rdata !== ~wb[b]) begin
        errors++;
        $display("FAIL burst_ack[%0d]: got ack=%b rdata=%h, expected 1/%h",
                 b, got, bus.m1_rdata, ~wb[b]);
      end
      if (b == 0) set_req(0, 1, 0, 8'h77, 8'h03);
      if (b < 2) set_req(1, 1, (b == 0), wb[b+1], 8'h03);
      else       set_req(1, 0, 0, 8'h00, 8'h03);
    end
    checks++;
    if (ack0_cnt != a0 || log_addr.size() != 5) begin
      errors++;
      $display("FAIL burst_blocked: got m0 acks=%0d writes=%0d, expected 0/5",
               ack0_cnt - a0, log_addr.size());
    end
    wait_ack(0, 300, got);
    checks++;
    if (!got || bus.m0_rdata !== 8'h88) begin
      errors++;
      $display("FAIL burst_m0_after: got ack=%b rdata=%h, expected 1/88", got, bus.m0_rdata);
    end
    set_req(0, 0, 0, 8'h00, 8'h03);
    wait_idle(300, ok);
    checks++;
    if (!ok || log_addr.size() != 9) begin
      errors++;
      $display("FAIL burst_count: got idle=%b writes=%0d, expected 1/9", ok, log_addr.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (log_addr[i] !== ea[i] || log_din[i] !== ed[i]) begin
          errors++;
          $display("FAIL burst_wr[%0d]: got %h/%h, expected %h/%h",
                   i, log_addr[i], log_din[i], ea[i], ed[i]);
        end
      end
    end
    checks++;
    if (ack0_cnt - a0 != 1 || ack1_cnt - a1 != 3 || bus.owner !== 1'b0) begin
      errors++;
      $display("FAIL burst_totals: got m0=%0d m1=%0d owner=%b, expected 1/3/0",
               ack0_cnt - a0, ack1_cnt - a1, bus.owner);
    end
  endtask

  task automatic test_round_robin();
    bit ok, got, who;
    logic [7:0] w0, w1, rd, exp_rd;
    apply_reset();
    wait_idle(50, ok);
    w0 = 8'h01; w1 = 8'h02;
    set_req(0, 1, 0, w0, 8'h03);
    set_req(1, 1, 0, w1, 8'h03);
    for (int k = 0; k < 4; k++) begin
      got = 0; who = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (bus.m0_ack === 1'b1 || bus.m1_ack === 1'b1) begin
          got = 1;
          who = (bus.m1_ack === 1'b1);
          break;
        end
      end
      rd     = who ? bus.m1_rdata : bus.m0_rdata;
      exp_rd = who ? ~w1 : ~w0;
      checks++;
      if (!got || who !== k[0] || rd !== exp_rd) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got ack=%b m%0d rdata=%h, expected m%0d rdata=%h",
                 k, got, who, rd, k[0], exp_rd);
      end
      if (k == 3) begin
        set_req(0, 0, 0, 8'h00, 8'h03);
        set_req(1, 0, 0, 8'h00, 8'h03);
      end else if (who) begin
        w1 = w1 + 8'h10;
        set_req(1, 1, 0, w1, 8'h03);
      end else begin
        w0 = w0 + 8'h10;
        set_req(0, 1, 0, w0, 8'h03);
      end
    end
    wait_idle(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_idle: busy=%b, expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    bit ok, got;
    int a0, a1;
    logic [11:0] ea[4];
    logic [15:0] ed[4];
    ea = '{ADIV, ACS, ADATA, ACS};
    ed = '{16'h0300, 16'h0001, 16'h0012, 16'h0000};
    apply_reset();
    wait_idle(50, ok);
    log_addr.delete(); log_din.delete();
    set_req(0, 1, 0, 8'h99, 8'h03);
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (log_addr.size() == 3 && eng_ready == 1'b0 && bus.spi_iowr_echo === bus.spi_iowr) begin
        got = 1;
        break;
      end
    end
    @(negedge clk);
    checks++;
    if (!got || bus.spi_iowr !== 1'b1 || bus.m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL rmid_setup: got reached=%b iowr=%b ack=%b, expected 1/1/0",
               got, bus.spi_iowr, bus.m0_ack);
    end
    a0 = ack0_cnt; a1 = ack1_cnt;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.spi_addr, bus.spi_din, bus.spi_iowr, bus.m0_ack, bus.m1_ack} !== 31'h0 ||
        bus.busy !== 1'b1 || bus.owner !== 1'b1) begin
      errors++;
      $display("FAIL rmid_outputs: got addr=%h din=%h iowr=%b busy=%b owner=%b, expected 0/0/0/1/1",
               bus.spi_addr, bus.spi_din, bus.spi_iowr, bus.busy, bus.owner);
    end
    set_req(0, 0, 0, 8'h00, 8'h03);
    log_addr.delete(); log_din.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_idle(300, ok);
    repeat (15) @(negedge clk);
    checks++;
    if (!ok || log_addr.size() != 0 || ack0_cnt != a0 || ack1_cnt != a1) begin
      errors++;
      $display("FAIL rmid_quiet: got idle=%b writes=%0d acks=%0d/%0d, expected 1/0/0/0",
               ok, log_addr.size(), ack0_cnt - a0, ack1_cnt - a1);
    end
    set_req(0, 1, 0, 8'h12, 8'h03);
    wait_ack(0, 300, got);
    checks++;
    if (!got || bus.m0_rdata !== 8'hED) begin
      errors++;
      $display("FAIL rmid_next_ack: got ack=%b rdata=%h, expected 1/ed", got, bus.m0_rdata);
    end
    set_req(0, 0, 0, 8'h00, 8'h03);
    wait_idle(300, ok);
    checks++;
    if (!ok || log_addr.size() != 4) begin
      errors++;
      $display("FAIL rmid_next_count: got idle=%b writes=%0d, expected 1/4", ok, log_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_addr[i] !== ea[i] || log_din[i] !== ed[i]) begin
          errors++;
          $display("FAIL rmid_next_wr[%0d]: got %h/%h, expected %h/%h",
                   i, log_addr[i], log_din[i], ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_echo_delay();
    bit in_wait, got;
    int run, max_run;
    logic [11:0] ca;
    logic [15:0] cd;
    logic        ci;
    logic [11:0] ea[3];
    logic [15:0] ed[3];
    ea = '{ACS, ADATA, ACS};
    ed = '{16'h0001, 16'h003C, 16'h0000};
    in_wait = 0; got = 0; run = 0; max_run = 0;
    ca = '0; cd = '0; ci = 1'b0;
    echo_delay = 5;
    log_addr.delete(); log_din.delete();
    set_req(0, 1, 0, 8'h3C, 8'h03);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.spi_iowr !== bus.spi_iowr_echo) begin
        if (!in_wait) begin
          in_wait = 1; run = 1;
          ca = bus.spi_addr; cd = bus.spi_din; ci = bus.spi_iowr;
        end else begin
          run++;
          checks++;
          if (bus.spi_addr !== ca || bus.spi_din !== cd || bus.spi_iowr !== ci) begin
            errors++;
            $display("FAIL echo_stable: got %h/%h/%b, expected %h/%h/%b",
                     bus.spi_addr, bus.spi_din, bus.spi_iowr, ca, cd, ci);
          end
        end
        if (run > max_run) max_run = run;
      end else begin
        in_wait = 0;
      end
      if (bus.m0_ack === 1'b1) begin
        got = 1;
        checks++;
        if (bus.m0_rdata !== 8'hC3) begin
          errors++;
          $display("FAIL echo_rdata: got %h, expected c3", bus.m0_rdata);
        end
        set_req(0, 0, 0, 8'h00, 8'h03);
      end
      if (got && bus.busy === 1'b0) break;
    end
    echo_delay = 0;
    checks++;
    if (!got || max_run < 5) begin
      errors++;
      $display("FAIL echo_wait: got ack=%b longest wait=%0d, expected 1/>=5", got, max_run);
    end
    checks++;
    if (log_addr.size() != 3) begin
      errors++;
      $display("FAIL echo_count: got %0d writes, expected 3", log_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (log_addr[i] !== ea[i] || log_din[i] !== ed[i]) begin
          errors++;
          $display("FAIL echo_wr[%0d]: got %h/%h, expected %h/%h",
                   i, log_addr[i], log_din[i], ea[i], ed[i]);
        end
      end
    end
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL ack_exclusive: got %0d cycles with both acks, expected 0", both_cnt);
    end
  endtask

  initial begin
    set_req(0, 0, 0, 8'h00, 8'h00);
    set_req(1, 0, 0, 8'h00, 8'h00);
    test_reset();
    test_single();
    test_div_cache();
    test_burst();
    test_round_robin();
    test_reset_mid();
    test_echo_delay();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
